// File: rtl/seq_divider_pkg.sv
// Shared definitions for the multdiv divider: FSM state encoding and the default operand width.
package seq_divider_pkg;

  localparam int DIV_WIDTH_DEFAULT = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } div_state_e;

endpackage

// File: rtl/seq_divider_div_stage.sv
// One combinational restoring-division step on unsigned magnitudes: shift {rem,quo} left,
// trial-subtract the divisor, keep the difference only when it does not borrow.
module seq_divider_div_stage #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem_i,
  input  logic [WIDTH-1:0] quo_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic [WIDTH-1:0] rem_o,
  output logic [WIDTH-1:0] quo_o
);

  logic [WIDTH:0] shifted;
  logic [WIDTH:0] diff;
  logic           borrow;

  // The partial remainder stays below the divisor, so one extra bit is enough to see the borrow.
  assign shifted = {rem_i, quo_i[WIDTH-1]};
  assign diff    = shifted - {1'b0, divisor_i};
  assign borrow  = diff[WIDTH];

  assign rem_o = borrow ? shifted[WIDTH-1:0] : diff[WIDTH-1:0];
  assign quo_o = {quo_i[WIDTH-2:0], ~borrow};

endmodule

// File: rtl/seq_divider.sv
// Multicycle signed divider (one restoring step per clock) behind the multdiv handshake.
// Define DIV_REMAINDER_EN to expose the signed remainder on data_remainder.
module seq_divider
  import seq_divider_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH_DEFAULT
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             ctrl_DIV,
  input  logic [WIDTH-1:0] data_operandA,
  input  logic [WIDTH-1:0] data_operandB,
  output logic [WIDTH-1:0] data_result,
  output logic             data_exception,
  output logic             data_resultRDY,
  output logic             busy
`ifdef DIV_REMAINDER_EN
  ,
  output logic [WIDTH-1:0] data_remainder
`endif
);

  localparam int CW = $clog2(WIDTH + 1);

  div_state_e       state_q;
  logic [CW-1:0]    count_q;
  logic [WIDTH-1:0] rem_q;
  logic [WIDTH-1:0] quo_q;
  logic [WIDTH-1:0] div_q;
  logic             sign_q;
  logic [WIDTH-1:0] result_q;
  logic             exc_q;
  logic             rdy_q;
  logic             busy_q;
  logic [WIDTH-1:0] rem_d;
  logic [WIDTH-1:0] quo_d;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;
  logic             div_zero;

`ifdef DIV_REMAINDER_EN
  logic             sign_r_q;
  logic [WIDTH-1:0] rem_res_q;
`endif

  // MIN_INT maps onto itself here, which is exactly its unsigned magnitude.
  assign a_mag    = data_operandA[WIDTH-1] ? -data_operandA : data_operandA;
  assign b_mag    = data_operandB[WIDTH-1] ? -data_operandB : data_operandB;
  assign div_zero = (data_operandB == '0);

  seq_divider_div_stage #(
    .WIDTH(WIDTH)
  ) u_stage (
    .rem_i    (rem_q),
    .quo_i    (quo_q),
    .divisor_i(div_q),
    .rem_o    (rem_d),
    .quo_o    (quo_d)
  );

  // Start is honoured only from IDLE or DONE; a start seen while running is dropped.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      count_q   <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      div_q     <= '0;
      sign_q    <= 1'b0;
      result_q  <= '0;
      exc_q     <= 1'b0;
      rdy_q     <= 1'b0;
      busy_q    <= 1'b0;
`ifdef DIV_REMAINDER_EN
      sign_r_q  <= 1'b0;
      rem_res_q <= '0;
`endif
    end else begin
      rdy_q <= 1'b0;
      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (ctrl_DIV) begin
            rem_q   <= '0;
            quo_q   <= a_mag;
            div_q   <= b_mag;
            sign_q  <= data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
            count_q <= '0;
`ifdef DIV_REMAINDER_EN
            sign_r_q <= data_operandA[WIDTH-1];
`endif
            if (div_zero) begin
              state_q  <= ST_DONE;
              result_q <= '0;
              exc_q    <= 1'b1;
              rdy_q    <= 1'b1;
`ifdef DIV_REMAINDER_EN
              rem_res_q <= '0;
`endif
            end else begin
              state_q <= ST_RUN;
              busy_q  <= 1'b1;
            end
          end else begin
            state_q <= ST_IDLE;
          end
        end
        ST_RUN: begin
          rem_q <= rem_d;
          quo_q <= quo_d;
          if (count_q == CW'(WIDTH - 1)) begin
            state_q  <= ST_DONE;
            count_q  <= '0;
            result_q <= sign_q ? -quo_d : quo_d;
            exc_q    <= 1'b0;
            rdy_q    <= 1'b1;
            busy_q   <= 1'b0;
`ifdef DIV_REMAINDER_EN
            rem_res_q <= sign_r_q ? -rem_d : rem_d;
`endif
          end else begin
            count_q <= count_q + CW'(1);
          end
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign data_result    = result_q;
  assign data_exception = exc_q;
  assign data_resultRDY = rdy_q;
  assign busy           = busy_q;
`ifdef DIV_REMAINDER_EN
  assign data_remainder = rem_res_q;
`endif

endmodule
